iterative_alu: RTL

ITERATIVE_ALU -- requirements
Module: iterative_alu

---
 rtl/iterative_alu.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/iterative_alu.sv
// Multi-cycle ALU: non-shift ops finish 2 cycles after start, shifts take shamt+2 cycles (one bit per cycle).
// No backpressure: start is honoured only in IDLE, and done pulses for a single cycle.
module iterative_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      ALUSelection,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1110;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;

  state_t          state, state_n;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      op_sel;
  logic [4:0]      count;
  logic [XLEN-1:0] work;

  logic [XLEN-1:0] exec_res;
  logic            exec_illegal;
  logic [XLEN-1:0] shift_step;
  logic            start_is_shift;

  assign start_is_shift = (ALUSelection == OP_SLL) || (ALUSelection == OP_SRL) ||
                          (ALUSelection == OP_SRA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = start_is_shift ? SHIFT : EXEC;
      EXEC:    state_n = DONE;
      SHIFT:   if (count == 5'd0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Single-cycle datapath for everything except shifts; unknown codes give 0 and flag illegal.
  always_comb begin
    exec_res     = '0;
    exec_illegal = 1'b0;
    case (op_sel)
      OP_ADD, OP_ADDI: exec_res = op_a + op_b;
      OP_SUB:          exec_res = op_a - op_b;
      OP_AND:          exec_res = op_a & op_b;
      OP_OR:           exec_res = op_a | op_b;
      OP_XOR:          exec_res = op_a ^ op_b;
      OP_SLT:          exec_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:         exec_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:         exec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    shift_step = work;
    case (op_sel)
      OP_SLL:  shift_step = {work[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, work[XLEN-1:1]};
      OP_SRA:  shift_step = {work[XLEN-1], work[XLEN-1:1]};
      default: shift_step = work;
    endcase
  end

  // Operands latch only on acceptance; the shift works on its own copy so op_a stays intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_sel  <= '0;
      count   <= '0;
      work    <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= A;
            op_b   <= B;
            op_sel <= ALUSelection;
            count  <= B[4:0];
            work   <= A;
          end
        end
        EXEC: begin
          result  <= exec_res;
          zero    <= (exec_res == '0);
          illegal <= exec_illegal;
        end
        SHIFT: begin
          if (count != 5'd0) begin
            work  <= shift_step;
            count <= count - 5'd1;
          end else begin
            result  <= work;
            zero    <= (work == '0);
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
